hazard_flush_ctrl: RTL and testbench
====================================

// Module: hazard_flush_ctrl
// PURPOSE
//  Pipeline sequencer for the ID-stage branch comparator and the IF/ID, ID/EX registers.
//  Detects load-use and branch-operand hazards and sequences 1- or 2-cycle stalls.
//  Gates the branch unit's taken/flush signal so it only acts on valid operands.
//  Keeps saturating stall and flush statistics. Sits beside the hazard path in the CPU top level.
// PARAMETERS
//  CNT_W    32  width of the stall and flush statistic counters
// PORTS
//  clk_i          in   1      clock; all state updates on the rising edge
//  rst_i          in   1      synchronous reset, active high
//  start_i        in   1      leaves IDLE once high
//  ID_RS1addr_i   in   5      rs1 of the instruction in ID
//  ID_RS2addr_i   in   5      rs2 of the instruction in ID
//  ID_Branch_i    in   1      instruction in ID is a beq
//  ID_Flush_i     in   1      branch unit: rs1==rs2 and Branch (raw taken)
//  EX_RDaddr_i    in   5      rd in EX
//  EX_RegWrite_i  in   1      EX instruction writes rd
//  EX_MemRead_i   in   1      EX instruction is a load
//  MEM_RDaddr_i   in   5      rd in MEM
//  MEM_MemRead_i  in   1      MEM instruction is a load
//  PCWrite_o      out  1      1 = PC may update
//  IF_ID_Write_o  out  1      1 = IF/ID may update
//  NoOp_o         out  1      1 = insert bubble into ID/EX
//  Flush_o        out  1      1 = clear IF/ID (qualified taken branch)
//  Stall_cnt_o    out  CNT_W  count of stall cycles (saturating)
//  Flush_cnt_o    out  CNT_W  count of flush cycles (saturating)
//  Busy_o         out  1      1 when state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE, stall counter=0, Stall_cnt_o=0, Flush_cnt_o=0.
//  In IDLE: PCWrite_o=0, IF_ID_Write_o=0, NoOp_o=1, Flush_o=0.
//  IDLE->RUN on the first edge with start_i=1.
//  Match(x): x!=0, and x equals ID_RS1addr_i or ID_RS2addr_i.
//  Hazard classes, evaluated combinationally in RUN:
//   H2: ID_Branch_i & EX_MemRead_i & Match(EX_RDaddr_i) -> 2 stall cycles.
//   H1, any of the following -> 1 stall cycle:
//    EX_MemRead_i & Match(EX_RDaddr_i) with ID_Branch_i=0;
//    ID_Branch_i & EX_RegWrite_i & !EX_MemRead_i & Match(EX_RDaddr_i);
//    ID_Branch_i & MEM_MemRead_i & Match(MEM_RDaddr_i).
//  H2 has priority over H1.
//  Stall outputs are Mealy, asserted the same cycle as detection:
//   PCWrite_o=0, IF_ID_Write_o=0, NoOp_o=1.
//  RUN->STALL on H2: 2-bit stall counter loaded with 1 (remaining cycles).
//  In STALL: stall outputs held, hazard inputs ignored, counter decrements.
//   STALL->RUN on the edge where the counter reaches 0.
//  H1 is served in RUN alone (one stall cycle); the re-check in the next cycle is
//   naturally clear because the bubble has advanced.
//  Flush_o = ID_Flush_i & ID_Branch_i & state==RUN & no hazard this cycle.
//   A stalled branch never flushes.
//  Flush_o with no stall: PCWrite_o=1, IF_ID_Write_o=1, NoOp_o=0.
//  Stall_cnt_o += 1 on every cycle with a stall output asserted (RUN hazard or STALL);
//   saturates at all-ones.
//  Flush_cnt_o += 1 on every cycle with Flush_o=1; saturates at all-ones.
//  rst_i mid-stall: aborts to IDLE the next edge, counters cleared.
//  start_i is ignored outside IDLE.
//  x0 never creates a hazard.
// STRUCTURE
//  Shared package (cpu_pkg):
//   state encoding IDLE=2'd0, RUN=2'd1, STALL=2'd2;
//   REG_ZERO=5'd0; REG_AW=5.
//  One natural sub-module: sat_counter (CNT_W, inc_i, clr_i, cnt_o), instanced twice.
// TESTING
//  1. Load-use stall
//     rst 2 cycles, start_i=1; EX_MemRead=1, EX_RD=5, ID_RS2=5, Branch=0
//     -> 1 cycle PCWrite=0, NoOp=1; Stall_cnt=1.
//  2. Load before branch
//     EX_MemRead=1, EX_RD=3, ID_RS1=3, Branch=1, ID_Flush_i=1
//     -> 2 stall cycles, Flush_o=0 throughout; Stall_cnt=2.
//  3. ALU producer before branch
//     EX_RegWrite=1, EX_RD=7, ID_RS2=7, Branch=1
//     -> 1 stall cycle; next cycle ID_Flush_i=1 -> Flush_o=1, Flush_cnt=1.
//  4. x0 never stalls
//     EX_MemRead=1, EX_RD=0, ID_RS1=0 -> no stall, PCWrite=1.
//  5. Reset mid-stall
//     assert rst_i during the second H2 stall cycle
//     -> next edge IDLE, Busy=0, Stall_cnt=0; start_i required to resume.
//  6. Saturation
//     CNT_W=2; 5 consecutive load-use stalls -> Stall_cnt_o holds 2'b11.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared pipeline-control types: sequencer state encoding, register-address constants and
// the operand-match helper used by the hazard logic.
package cpu_pkg;

   localparam int unsigned REG_AW = 5;
   localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StRun   = 2'd1,
      StStall = 2'd2
   } state_e;

   // x0 is hard-wired to zero, so it never carries a dependency.
   function automatic logic reg_match(input logic [REG_AW-1:0] x,
                                      input logic [REG_AW-1:0] rs1,
                                      input logic [REG_AW-1:0] rs2);
      return (x != REG_ZERO) && ((x == rs1) || (x == rs2));
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Statistic counter: increments on inc_i, sticks at all-ones, synchronous clear.
module sat_counter #(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk_i,
   input  logic             clr_i,
   input  logic             inc_i,
   output logic [CNT_W-1:0] cnt_o
);

   logic [CNT_W-1:0] r_cnt;
   logic             w_sat;

   assign w_sat = &r_cnt;
   assign cnt_o = r_cnt;

   always_ff @(posedge clk_i) begin
      if (clr_i) begin
         r_cnt <= '0;
      end else if (inc_i && !w_sat) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/hazard_flush_ctrl.sv
// ID-stage hazard sequencer: detects load-use and branch-operand hazards, sequences
// one- or two-cycle stalls, qualifies branch flushes and keeps stall/flush statistics.
module hazard_flush_ctrl
   import cpu_pkg::*;
#(
   parameter int unsigned CNT_W = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic [REG_AW-1:0] ID_RS1addr_i,
   input  logic [REG_AW-1:0] ID_RS2addr_i,
   input  logic              ID_Branch_i,
   input  logic              ID_Flush_i,
   input  logic [REG_AW-1:0] EX_RDaddr_i,
   input  logic              EX_RegWrite_i,
   input  logic              EX_MemRead_i,
   input  logic [REG_AW-1:0] MEM_RDaddr_i,
   input  logic              MEM_MemRead_i,
   output logic              PCWrite_o,
   output logic              IF_ID_Write_o,
   output logic              NoOp_o,
   output logic              Flush_o,
   output logic [CNT_W-1:0]  Stall_cnt_o,
   output logic [CNT_W-1:0]  Flush_cnt_o,
   output logic              Busy_o
);

   state_e     r_state, w_state_d;
   logic [1:0] r_stall_cnt, w_stall_cnt_d;
   logic       w_m_ex, w_m_mem;
   logic       w_h1, w_h2, w_hazard;
   logic       w_stall;

   assign w_m_ex  = reg_match(EX_RDaddr_i, ID_RS1addr_i, ID_RS2addr_i);
   assign w_m_mem = reg_match(MEM_RDaddr_i, ID_RS1addr_i, ID_RS2addr_i);

   // A branch compares in ID, so a load feeding it must wait until the data leaves MEM.
   assign w_h2 = ID_Branch_i & EX_MemRead_i & w_m_ex;
   assign w_h1 = (EX_MemRead_i & w_m_ex & ~ID_Branch_i)
               | (ID_Branch_i & EX_RegWrite_i & ~EX_MemRead_i & w_m_ex)
               | (ID_Branch_i & MEM_MemRead_i & w_m_mem);
   assign w_hazard = w_h2 | w_h1;

   assign Busy_o = (r_state != StIdle);

   always_comb begin
      w_state_d     = r_state;
      w_stall_cnt_d = r_stall_cnt;
      PCWrite_o     = 1'b0;
      IF_ID_Write_o = 1'b0;
      NoOp_o        = 1'b1;
      Flush_o       = 1'b0;
      w_stall       = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (start_i) w_state_d = StRun;
         end
         StRun: begin
            if (w_hazard) begin
               w_stall = 1'b1;
               if (w_h2) begin
                  w_state_d     = StStall;
                  w_stall_cnt_d = 2'd1;
               end
            end else begin
               PCWrite_o     = 1'b1;
               IF_ID_Write_o = 1'b1;
               NoOp_o        = 1'b0;
               Flush_o       = ID_Flush_i & ID_Branch_i;
            end
         end
         StStall: begin
            w_stall       = 1'b1;
            w_stall_cnt_d = r_stall_cnt - 2'd1;
            if (w_stall_cnt_d == 2'd0) w_state_d = StRun;
         end
         default: begin
            w_state_d     = StIdle;
            w_stall_cnt_d = 2'd0;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state     <= StIdle;
         r_stall_cnt <= 2'd0;
      end else begin
         r_state     <= w_state_d;
         r_stall_cnt <= w_stall_cnt_d;
      end
   end

   sat_counter #(
      .CNT_W (CNT_W)
   ) u_stall_cnt (
      .clk_i (clk_i),
      .clr_i (rst_i),
      .inc_i (w_stall),
      .cnt_o (Stall_cnt_o)
   );

   sat_counter #(
      .CNT_W (CNT_W)
   ) u_flush_cnt (
      .clk_i (clk_i),
      .clr_i (rst_i),
      .inc_i (Flush_o),
      .cnt_o (Flush_cnt_o)
   );

endmodule

// File: tb/tb_hazard_flush_ctrl.sv
// Bench for hazard_flush_ctrl: directed scenarios plus random traffic against a cycle model
// built from the hazard rules; a second instance with 2-bit counters covers saturation.
module tb_hazard_flush_ctrl;

   logic       clk = 1'b0;
   logic       rst, start, br, idf, exrw, exmr, memmr;
   logic [4:0] rs1, rs2, exrd, memrd;

   logic        pcw, ifid, noop, flush, busy;
   logic [31:0] scnt, fcnt;
   logic        pcw2, ifid2, noop2, flush2, busy2;
   logic [1:0]  scnt2, fcnt2;
   logic [4:0]  got, got2, exp;

   int vectors = 0;
   int fails   = 0;

   // Reference model state
   bit     m_run;
   int     m_left;
   longint m_sc, m_fc;

   always #5 clk = ~clk;

   assign got  = {pcw, ifid, noop, flush, busy};
   assign got2 = {pcw2, ifid2, noop2, flush2, busy2};

   hazard_flush_ctrl #(.CNT_W(32)) dut (
      .clk_i(clk), .rst_i(rst), .start_i(start),
      .ID_RS1addr_i(rs1), .ID_RS2addr_i(rs2), .ID_Branch_i(br), .ID_Flush_i(idf),
      .EX_RDaddr_i(exrd), .EX_RegWrite_i(exrw), .EX_MemRead_i(exmr),
      .MEM_RDaddr_i(memrd), .MEM_MemRead_i(memmr),
      .PCWrite_o(pcw), .IF_ID_Write_o(ifid), .NoOp_o(noop), .Flush_o(flush),
      .Stall_cnt_o(scnt), .Flush_cnt_o(fcnt), .Busy_o(busy)
   );

   hazard_flush_ctrl #(.CNT_W(2)) dut2 (
      .clk_i(clk), .rst_i(rst), .start_i(start),
      .ID_RS1addr_i(rs1), .ID_RS2addr_i(rs2), .ID_Branch_i(br), .ID_Flush_i(idf),
      .EX_RDaddr_i(exrd), .EX_RegWrite_i(exrw), .EX_MemRead_i(exmr),
      .MEM_RDaddr_i(memrd), .MEM_MemRead_i(memmr),
      .PCWrite_o(pcw2), .IF_ID_Write_o(ifid2), .NoOp_o(noop2), .Flush_o(flush2),
      .Stall_cnt_o(scnt2), .Flush_cnt_o(fcnt2), .Busy_o(busy2)
   );

   // Stall cycles the current ID instruction needs, straight from the hazard table.
   function automatic int hazard_need();
      bit mex, mmem;
      mex  = (exrd != 0) && (exrd == rs1 || exrd == rs2);
      mmem = (memrd != 0) && (memrd == rs1 || memrd == rs2);
      if (br && exmr && mex) return 2;
      if ((exmr && mex && !br) || (br && exrw && !exmr && mex) || (br && memmr && mmem))
         return 1;
      return 0;
   endfunction

   // {PCWrite, IF_ID_Write, NoOp, Flush, Busy}
   function automatic logic [4:0] model_out();
      if (!m_run) return 5'b00100;
      if (m_left > 0 || hazard_need() > 0) return 5'b00101;
      return {1'b1, 1'b1, 1'b0, idf & br, 1'b1};
   endfunction

   function automatic logic [1:0] sat2(input longint v);
      return (v >= 3) ? 2'd3 : v[1:0];
   endfunction

   // Advance the model by one clock using the inputs present now, then move to next negedge.
   task automatic adv();
      int need;
      need = hazard_need();
      if (rst) begin
         m_run = 0; m_left = 0; m_sc = 0; m_fc = 0;
      end else if (!m_run) begin
         m_run = start;
      end else if (m_left > 0) begin
         m_sc++;
         m_left--;
      end else if (need > 0) begin
         m_sc++;
         m_left = need - 1;
      end else if (idf && br) begin
         m_fc++;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic clear_inputs();
      start = 0; br = 0; idf = 0; exrw = 0; exmr = 0; memmr = 0;
      rs1 = 0; rs2 = 0; exrd = 0; memrd = 0;
   endtask

   task automatic reset_and_start();
      clear_inputs();
      rst = 1;
      adv();
      adv();
      rst = 0;
      start = 1;
      adv();
      start = 0;
   endtask

   task automatic test_reset();
      clear_inputs();
      rst = 1;
      adv();
      adv();
      rst = 0;
      #2;
      vectors++;
      if (got !== 5'b00100 || scnt !== 32'd0 || fcnt !== 32'd0) begin
         fails++;
         $display("FAIL reset: outs=%b cnt=%0d/%0d want 00100 0/0", got, scnt, fcnt);
      end
      adv();
      #2;
      vectors++;
      if (busy !== 1'b0) begin
         fails++;
         $display("FAIL idle_no_start: busy=%b want 0", busy);
      end
      start = 1;
      adv();
      start = 0;
      #2;
      vectors++;
      if (got !== 5'b11001) begin
         fails++;
         $display("FAIL start_run: outs=%b want 11001", got);
      end
   endtask

   task automatic test_load_use();
      reset_and_start();
      exmr = 1; exrd = 5; rs2 = 5; rs1 = 9;
      #2;
      vectors++;
      if (got !== 5'b00101) begin
         fails++;
         $display("FAIL load_use_stall: outs=%b want 00101", got);
      end
      adv();
      exmr = 0; exrd = 0;
      #2;
      vectors++;
      if (got !== 5'b11001 || scnt !== 32'd1) begin
         fails++;
         $display("FAIL load_use_release: outs=%b scnt=%0d want 11001 1", got, scnt);
      end
   endtask

   task automatic test_load_branch();
      reset_and_start();
      exmr = 1; exrd = 3; rs1 = 3; rs2 = 8; br = 1; idf = 1;
      for (int c = 0; c < 2; c++) begin
         #2;
         vectors++;
         if (got !== 5'b00101) begin
            fails++;
            $display("FAIL load_branch_c%0d: outs=%b want 00101", c, got);
         end
         adv();
         exmr = 0; exrd = 0; memmr = 1; memrd = 3;
      end
      memmr = 0; memrd = 0;
      #2;
      vectors++;
      if (scnt !== 32'd2 || fcnt !== 32'd0 || got !== 5'b11011) begin
         fails++;
         $display("FAIL load_branch_after: outs=%b scnt=%0d fcnt=%0d want 11011 2 0",
                  got, scnt, fcnt);
      end
   endtask

   task automatic test_alu_branch();
      reset_and_start();
      exrw = 1; exrd = 7; rs2 = 7; rs1 = 2; br = 1; idf = 1;
      #2;
      vectors++;
      if (got !== 5'b00101) begin
         fails++;
         $display("FAIL alu_branch_stall: outs=%b want 00101", got);
      end
      adv();
      exrw = 0; exrd = 0;
      #2;
      vectors++;
      if (got !== 5'b11011) begin
         fails++;
         $display("FAIL alu_branch_flush: outs=%b want 11011", got);
      end
      adv();
      br = 0; idf = 0;
      #2;
      vectors++;
      if (fcnt !== 32'd1 || scnt !== 32'd1) begin
         fails++;
         $display("FAIL alu_branch_cnt: fcnt=%0d scnt=%0d want 1 1", fcnt, scnt);
      end
   endtask

   task automatic test_x0();
      reset_and_start();
      exmr = 1; exrd = 0; rs1 = 0; rs2 = 0; br = 1; memmr = 1; memrd = 0;
      #2;
      vectors++;
      if (got !== 5'b11001) begin
         fails++;
         $display("FAIL x0_no_stall: outs=%b want 11001", got);
      end
   endtask

   task automatic test_reset_mid_stall();
      reset_and_start();
      exmr = 1; exrd = 4; rs1 = 4; br = 1;
      adv();
      clear_inputs();
      rst = 1;
      #2;
      vectors++;
      if (got !== 5'b00101) begin
         fails++;
         $display("FAIL mid_stall_second: outs=%b want 00101", got);
      end
      adv();
      rst = 0;
      #2;
      vectors++;
      if (got !== 5'b00100 || scnt !== 32'd0) begin
         fails++;
         $display("FAIL mid_stall_abort: outs=%b scnt=%0d want 00100 0", got, scnt);
      end
      adv();
      #2;
      vectors++;
      if (busy !== 1'b0) begin
         fails++;
         $display("FAIL mid_stall_needs_start: busy=%b want 0", busy);
      end
   endtask

   task automatic test_saturation();
      reset_and_start();
      exmr = 1; exrd = 6; rs2 = 6;
      for (int c = 0; c < 5; c++) adv();
      clear_inputs();
      #2;
      vectors++;
      if (scnt2 !== 2'b11 || scnt !== 32'd5) begin
         fails++;
         $display("FAIL saturation: scnt2=%b scnt=%0d want 11 5", scnt2, scnt);
      end
   endtask

   task automatic test_random();
      reset_and_start();
      for (int c = 0; c < 400; c++) begin
         rst   = ($urandom_range(0, 60) == 0);
         start = $urandom_range(0, 1);
         br    = $urandom_range(0, 1);
         idf   = $urandom_range(0, 1);
         exrw  = $urandom_range(0, 1);
         exmr  = $urandom_range(0, 1);
         memmr = $urandom_range(0, 1);
         rs1   = 5'($urandom_range(0, 3));
         rs2   = 5'($urandom_range(0, 3));
         exrd  = 5'($urandom_range(0, 3));
         memrd = 5'($urandom_range(0, 3));
         #2;
         exp = model_out();
         vectors++;
         if (got !== exp || scnt !== m_sc[31:0] || fcnt !== m_fc[31:0]) begin
            fails++;
            $display("FAIL random_c%0d: outs=%b scnt=%0d fcnt=%0d want %b %0d %0d",
                     c, got, scnt, fcnt, exp, m_sc, m_fc);
         end
         vectors++;
         if (got2 !== exp || scnt2 !== sat2(m_sc) || fcnt2 !== sat2(m_fc)) begin
            fails++;
            $display("FAIL random_w2_c%0d: outs=%b scnt=%0d fcnt=%0d want %b %0d %0d",
                     c, got2, scnt2, fcnt2, exp, sat2(m_sc), sat2(m_fc));
         end
         adv();
      end
   endtask

   initial begin
      clear_inputs();
      rst = 1;
      m_run = 0; m_left = 0; m_sc = 0; m_fc = 0;
      @(negedge clk);
      test_reset();
      test_load_use();
      test_load_branch();
      test_alu_branch();
      test_x0();
      test_reset_mid_stall();
      test_saturation();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

endmodule
